// File: rtl/axi4_iso_pkg.sv
// Shared types and helpers for the AXI4 timeout enforcer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi4_iso_pkg;

  // AXI4 awlen is always 8 bits wide.
  localparam int AWLEN_W = 8;

  typedef enum logic {
    W_PASS   = 1'b0,
    W_INJECT = 1'b1
  } w_state_e;

  // A counter that must be able to hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

  // Width of a pointer into a storage array of 'depth' entries.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi4_len_fifo.sv
// Burst-length FIFO: holds awlen of accepted AW bursts until their W data completes.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push is ignored when full and pop is ignored when empty; callers gate on full/empty.
//
// Ports: aclk/aresetn (sync, active-low), push/push_dat write side,
//        pop/pop_dat read side (pop_dat shows the head entry), full/empty status.
module axi4_len_fifo
  import axi4_iso_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               push,
  input  logic [AWLEN_W-1:0] push_dat,
  input  logic               pop,
  output logic [AWLEN_W-1:0] pop_dat,
  output logic               full,
  output logic               empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AWLEN_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      // Push and pop together leave occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/axi4_timeout_enforcer.sv
// AXI4 timeout enforcer: injects null W beats for stalled write bursts and sinks stalled B/R responses.
// Latency: zero-cycle combinational pass-through on every channel; timeouts act one cycle after the limit is seen.
// Backpressure: AW stalls while the length FIFO is full, W is held off while it is empty; B/R ready is forced after the stall limit.
//
// Ports: aclk/aresetn (sync, active-low); axi_s_* faces the upstream master, axi_m_* faces the downstream slave;
//        AW (awlen/valid/ready), W (wdata/wstrb/wlast/valid/ready), B (bid/bresp/valid/ready),
//        R (rid/rdata/rresp/rlast/valid/ready); w_timeout/b_timeout/r_timeout are sticky event flags.
module axi4_timeout_enforcer
  import axi4_iso_pkg::*;
#(
  parameter int AXI_ID_WIDTH     = 4,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int WTIMEOUT_CYCLES  = 15,
  parameter int BTIMEOUT_CYCLES  = 15,
  parameter int RTIMEOUT_CYCLES  = 15,
  parameter int OUTSTANDING_WREQ = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // AW
  input  logic [7:0]                  axi_s_awlen,
  input  logic                        axi_s_awvalid,
  output logic                        axi_s_awready,
  output logic [7:0]                  axi_m_awlen,
  output logic                        axi_m_awvalid,
  input  logic                        axi_m_awready,
  // W
  input  logic [AXI_DATA_WIDTH-1:0]   axi_s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_s_wstrb,
  input  logic                        axi_s_wlast,
  input  logic                        axi_s_wvalid,
  output logic                        axi_s_wready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_m_wstrb,
  output logic                        axi_m_wlast,
  output logic                        axi_m_wvalid,
  input  logic                        axi_m_wready,
  // B
  input  logic [AXI_ID_WIDTH-1:0]     axi_m_bid,
  input  logic [1:0]                  axi_m_bresp,
  input  logic                        axi_m_bvalid,
  output logic                        axi_m_bready,
  output logic [AXI_ID_WIDTH-1:0]     axi_s_bid,
  output logic [1:0]                  axi_s_bresp,
  output logic                        axi_s_bvalid,
  input  logic                        axi_s_bready,
  // R
  input  logic [AXI_ID_WIDTH-1:0]     axi_m_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_m_rdata,
  input  logic [1:0]                  axi_m_rresp,
  input  logic                        axi_m_rlast,
  input  logic                        axi_m_rvalid,
  output logic                        axi_m_rready,
  output logic [AXI_ID_WIDTH-1:0]     axi_s_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_s_rdata,
  output logic [1:0]                  axi_s_rresp,
  output logic                        axi_s_rlast,
  output logic                        axi_s_rvalid,
  input  logic                        axi_s_rready,
  // Sticky timeout flags
  output logic                        w_timeout,
  output logic                        b_timeout,
  output logic                        r_timeout
);

  localparam int WCW = cnt_width(WTIMEOUT_CYCLES);
  localparam int BCW = cnt_width(BTIMEOUT_CYCLES);
  localparam int RCW = cnt_width(RTIMEOUT_CYCLES);

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AWLEN_W-1:0] head_len;

  w_state_e           w_state;
  w_state_e           w_state_nxt;
  logic [AWLEN_W-1:0] beat_cnt;
  logic [WCW-1:0]     idle_cnt;
  logic               w_hs;
  logic               w_final;
  logic               w_enter;

  logic [BCW-1:0]     b_cnt;
  logic [RCW-1:0]     r_cnt;
  logic               b_force;
  logic               r_force;

  axi4_len_fifo #(
    .DEPTH (OUTSTANDING_WREQ)
  ) u_len_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (fifo_push),
    .push_dat (axi_s_awlen),
    .pop      (fifo_pop),
    .pop_dat  (head_len),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------- AW: decoupled while no room to track another burst ----------------
  always_comb begin
    axi_m_awlen   = axi_s_awlen;
    axi_m_awvalid = aresetn && !fifo_full && axi_s_awvalid;
    axi_s_awready = aresetn && !fifo_full && axi_m_awready;
  end

  assign fifo_push = axi_m_awvalid && axi_m_awready;

  // ---------------- W: pass-through or null-beat injection ----------------
  always_comb begin
    axi_m_wdata  = axi_s_wdata;
    axi_m_wstrb  = axi_s_wstrb;
    axi_m_wlast  = axi_s_wlast;
    axi_m_wvalid = 1'b0;
    axi_s_wready = 1'b0;
    if (aresetn && !fifo_empty) begin
      if (w_state == W_INJECT) begin
        // Null beats: no byte is written, the upstream master is held off.
        axi_m_wdata  = '0;
        axi_m_wstrb  = '0;
        axi_m_wlast  = w_final;
        axi_m_wvalid = 1'b1;
      end else begin
        axi_m_wvalid = axi_s_wvalid;
        axi_s_wready = axi_m_wready;
      end
    end
  end

  assign w_hs    = axi_m_wvalid && axi_m_wready;
  // Burst end is taken from our own beat count, never from the master's wlast.
  assign w_final = (beat_cnt == head_len);
  assign fifo_pop = w_hs && w_final;

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_PASS: begin
        if (!fifo_empty && !axi_s_wvalid && idle_cnt == WCW'(WTIMEOUT_CYCLES))
          w_state_nxt = W_INJECT;
      end
      W_INJECT: begin
        if (fifo_pop) w_state_nxt = W_PASS;
      end
      default: w_state_nxt = W_PASS;
    endcase
  end

  assign w_enter = (w_state == W_PASS) && (w_state_nxt == W_INJECT);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state   <= W_PASS;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      w_timeout <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (w_hs) beat_cnt <= w_final ? '0 : beat_cnt + AWLEN_W'(1);
      if (w_state != W_PASS || fifo_empty || axi_s_wvalid || w_enter)
        idle_cnt <= '0;
      else if (idle_cnt != WCW'(WTIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + WCW'(1);
      if (w_enter) w_timeout <= 1'b1;
    end
  end

  // ---------------- B: sink a response the upstream refuses for too long ----------------
  assign b_force = aresetn && (b_cnt == BCW'(BTIMEOUT_CYCLES));

  always_comb begin
    axi_s_bid    = axi_m_bid;
    axi_s_bresp  = axi_m_bresp;
    axi_s_bvalid = axi_m_bvalid && !b_force;
    axi_m_bready = axi_s_bready || b_force;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      b_cnt     <= '0;
      b_timeout <= 1'b0;
    end else if (b_force) begin
      b_cnt     <= '0;
      b_timeout <= 1'b1;
    end else if (axi_m_bvalid && !axi_s_bready) begin
      b_cnt <= b_cnt + BCW'(1);
    end else begin
      b_cnt <= '0;
    end
  end

  // ---------------- R: same stall rule, applied per beat ----------------
  assign r_force = aresetn && (r_cnt == RCW'(RTIMEOUT_CYCLES));

  always_comb begin
    axi_s_rid    = axi_m_rid;
    axi_s_rdata  = axi_m_rdata;
    axi_s_rresp  = axi_m_rresp;
    axi_s_rlast  = axi_m_rlast;
    axi_s_rvalid = axi_m_rvalid && !r_force;
    axi_m_rready = axi_s_rready || r_force;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (r_force) begin
      r_cnt     <= '0;
      r_timeout <= 1'b1;
    end else if (axi_m_rvalid && !axi_s_rready) begin
      r_cnt <= r_cnt + RCW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: doc/axi4_timeout_enforcer.md
AXI4_TIMEOUT_ENFORCER -- requirements
Module: axi4_timeout_enforcer

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4, sets the width of all ID signals.
REQ-002 Parameter AXI_DATA_WIDTH, default 128, sets the data path width (DW); strobe width is DW/8.
REQ-003 Parameter WTIMEOUT_CYCLES, default 15, is the W-channel idle limit in cycles; must be at least 1.
REQ-004 Parameter BTIMEOUT_CYCLES, default 15, is the B-channel bready stall limit in cycles; must be at least 1.
REQ-005 Parameter RTIMEOUT_CYCLES, default 15, is the R-channel rready stall limit in cycles; must be at least 1.
REQ-006 Parameter OUTSTANDING_WREQ, default 8, is the maximum number of tracked AW bursts.
REQ-007 aclk, input, 1 bit: clock; all ports are synchronous to it.
REQ-008 aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-009 axi_s_aw*, slave side: inputs awlen[8] and awvalid; output awready.
REQ-010 axi_m_aw*, master side: outputs awlen[8] and awvalid; input awready.
REQ-011 axi_s_w*, slave side: inputs wdata[DW], wstrb[DW/8], wlast and wvalid; output wready.
REQ-012 axi_m_w*, master side: outputs wdata, wstrb, wlast and wvalid; input wready.
REQ-013 axi_m_b*, master side: inputs bid[ID], bresp[2] and bvalid; output bready.
REQ-014 axi_s_b*, slave side: outputs bid, bresp and bvalid; input bready.
REQ-015 axi_m_r*, master side: inputs rid, rdata, rresp, rlast and rvalid; output rready.
REQ-016 axi_s_r*, slave side: outputs rid, rdata, rresp, rlast and rvalid; input rready.
REQ-017 w_timeout, b_timeout and r_timeout are 1-bit sticky outputs, each flagging one timeout event on its channel.

Function
REQ-018 All data, ID and response fields pass combinationally from input side to output side with zero latency, except during W injection.
REQ-019 An accepted AW (m_awvalid && m_awready) pushes awlen into the length FIFO.
REQ-020 When the length FIFO is full, the AW channel is decoupled: m_awvalid=0 and s_awready=0.
REQ-021 When the length FIFO is empty, the W channel is decoupled: m_wvalid=0 and s_wready=0.
REQ-022 A beat counter counts accepted W beats of the head burst; the FIFO pops on the final beat (count == awlen).
REQ-023 A simultaneous FIFO push and pop leaves the FIFO occupancy unchanged.
REQ-024 The W state machine has states W_PASS and W_INJECT; reset state is W_PASS.
REQ-025 In W_PASS, the idle counter increments each cycle the FIFO is non-empty and s_wvalid=0.
REQ-026 In W_PASS, the idle counter clears on s_wvalid=1 or when the FIFO is empty.
REQ-027 When the idle counter equals WTIMEOUT_CYCLES, the block enters W_INJECT on the next cycle and sets w_timeout.
REQ-028 In W_INJECT: m_wvalid=1, wdata=0, wstrb=0, s_wready=0, and wlast=1 only on the final beat of the head burst.
REQ-029 In W_INJECT, the beat counter advances on m_wready; after the final beat, the FIFO pops and the block returns to W_PASS.
REQ-030 Master beats of a burst aborted by injection are not re-accepted; the master requires reset after w_timeout.
REQ-031 The B stall counter increments while m_bvalid=1 and s_bready=0.
REQ-032 The B stall counter clears on a B handshake or when m_bvalid=0.
REQ-033 When the B stall counter equals BTIMEOUT_CYCLES, that cycle drives m_bready=1 and s_bvalid=0, sets b_timeout, and clears the counter.
REQ-034 R follows REQ-031 to REQ-033 per beat using RTIMEOUT_CYCLES, rready/rvalid and r_timeout.
REQ-035 Counter widths are clog2(limit+1); counters saturate and never wrap.
REQ-036 AW accept together with a W timeout in the same cycle still pushes the FIFO.

Reset
REQ-037 While aresetn=0, all of the following hold:
- FIFO empty; state W_PASS; all counters 0; all timeout flags 0.
- m_wvalid=0, s_wready=0, m_awvalid=0, s_awready=0.
- B and R valid/ready follow their pass-through inputs.
REQ-038 Reset mid-burst or mid-injection discards all tracked bursts, with no further injected beats.

Structure
REQ-039 Package axi4_iso_pkg holds the W state enum typedef and the clog2-based counter-width constant functions.
REQ-040 Sub-module axi4_len_fifo is a synchronous 8-bit FIFO of depth OUTSTANDING_WREQ with full and empty outputs.

Verification
REQ-041 Scenario, normal traffic: AW awlen=3, four W beats each 1 cycle apart -> all pass unmodified, FIFO empty after the beat with wlast=1, no flags set.
REQ-042 Scenario, W timeout: AW awlen=3, master sends 1 beat then idles 15 cycles (WTIMEOUT_CYCLES=15) -> 3 injected beats with wstrb=0, wlast on the third, w_timeout=1.
REQ-043 Scenario, AW backpressure: 8 AWs accepted with no W data -> 9th AW sees s_awready=0 and m_awvalid=0 until one burst completes.
REQ-044 Scenario, B stall: m_bvalid=1 and s_bready=0 for 15 cycles -> on cycle 15, m_bready=1, s_bvalid=0, b_timeout=1.
REQ-045 Scenario, R stall: 4-beat read, rready=0 after beat 2 -> beats 3 and 4 each sunk after 15 stall cycles, r_timeout=1.
REQ-046 Scenario, reset during W_INJECT: deassert aresetn for 1 cycle -> m_wvalid=0 next cycle, FIFO empty, flags cleared.
